std_delay_catcher: RTL and testbench
====================================

Name: std_delay_catcher

Overview:
- Receiving end of a fixed-latency pipeline built from std_delay, or any pipeline whose output arrives a fixed number of cycles after issue with no backpressure.
- Gates issue into the pipeline with a credit counter.
- Captures whatever emerges into a circular buffer and presents it downstream on a valid/ready handshake.
- Guarantees no result is lost when the consumer stalls.

Parameters:
- DEPTH, 4: buffer entries and total credits; must be >= 1.
- WIDTH, 1: data width.
- TYPE, logic [WIDTH-1:0]: data type.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_issue_valid  input  1  upstream requests to issue one operation into the pipeline.
- o_issue_ready  output  1  credit available; an issue occurs in a cycle where i_issue_valid and o_issue_ready are both high.
- i_pipe_valid  input  1  result emerging from the pipeline end this cycle.
- i_pipe_d  input  TYPE  result data.
- o_valid  output  1  buffer head valid.
- i_ready  input  1  downstream accepts the head.
- o_d  output  TYPE  buffer head data.
- o_credits  output  $clog2(DEPTH+1)  current credit count.
- o_error  output  1  sticky protocol-violation flag.

Behaviour:
- Interface: one clock i_clk; reset i_rst is asynchronous and active-low.
- Reset (i_rst low, asynchronous assert):
  - buffer emptied, write and read pointers set to 0;
  - o_credits = DEPTH, o_issue_ready = 1;
  - o_valid = 0, o_d = 0, o_error = 0.
- Reset takes effect mid-operation. The feeding pipeline shares this reset, so no pre-reset results arrive afterwards.
- Credits:
  - o_issue_ready = (o_credits != 0), derived from the register only; no combinational path from i_ready.
  - An issue decrements the counter; a pop (o_valid & i_ready) increments it. Both in the same cycle leave it unchanged.
  - Update is visible the next cycle.
  - Counter never goes below 0 or above DEPTH.
- Credit lifetime: a credit is held from the issue until the cycle after its pop.
- Throughput: with pipeline latency L and i_ready constantly high, one issue per cycle is sustained if DEPTH >= L+2.
- Push:
  - i_pipe_valid writes i_pipe_d at the write pointer; the write pointer advances modulo DEPTH.
  - Push is accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the data is dropped, buffer and pointers are unchanged, and o_error is set next cycle.
- Pop: on o_valid & i_ready the read pointer advances modulo DEPTH.
- Output timing:
  - o_valid/o_d are registered, with no push-to-output bypass.
  - Data pushed in cycle t is visible at the head at t+1 at the earliest.
  - Ordering is strict FIFO.
- Wrap-around: the pointers wrap at DEPTH (DEPTH need not be a power of 2). Full and empty are distinguished by an occupancy counter of width $clog2(DEPTH+1).
- Simultaneous push and pop when empty: the pop is not possible (o_valid = 0), so only the push occurs.
- Simultaneous push and pop when count == 1: the head advances to the new entry.
- o_error:
  - also set when a pop would occur with o_credits == DEPTH (inconsistent state);
  - sticky, cleared only by reset;
  - operation continues after an error.
- o_d holds its last value when o_valid = 0; do not check it.

Test Plan (WIDTH=8, DEPTH=4, std_delay DELAY=2 as pipeline, all results pushed):
1. Reset -> o_valid=0, o_issue_ready=1, o_credits=4, o_error=0; assert reset mid-stream with 2 entries buffered -> same values immediately.
2. Stall: i_ready=0, issue 0x11,0x22,0x33,0x44 on cycles 0-3 -> o_credits reaches 0 at cycle 4, o_issue_ready=0 from cycle 4, o_valid=1 with o_d=0x11 at cycle 3; a fifth i_issue_valid is not accepted.
3. Drain: after step 2, raise i_ready -> o_d shows 0x11,0x22,0x33,0x44 on consecutive cycles, o_valid low afterwards, o_credits=4 one cycle after the last pop.
4. Stream with DEPTH=4 (L+2): i_ready=1, issue 20 items 0..19 back-to-back -> o_issue_ready never drops, outputs 0..19 in order, one per cycle, item k visible at cycle k+3; repeat with DEPTH=3 -> o_issue_ready drops periodically, no loss, order preserved.
5. Wrap/simultaneous: hold occupancy at 2 with concurrent push and pop for 10 cycles -> pointers wrap twice, data in order, o_credits constant.
6. Overflow injection: buffer full, i_ready=0, force i_pipe_valid with 0xEE -> o_error=1 next cycle and stays 1, 0xEE never appears at o_d, the 4 stored entries drain intact.

Source files
------------

// File: rtl/std_delay_catcher.sv
// std_delay_catcher: credit-gated receiver for a fixed-latency, no-backpressure
// pipeline. Results are captured into a circular buffer and handed downstream
// on a valid/ready handshake; credits bound in-flight work so nothing is lost.
module std_delay_catcher #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1,
  parameter type         TYPE  = logic [WIDTH-1:0]
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_issue_valid,
  output logic                       o_issue_ready,
  input  logic                       i_pipe_valid,
  input  TYPE                        i_pipe_d,
  output logic                       o_valid,
  input  logic                       i_ready,
  output TYPE                        o_d,
  output logic [$clog2(DEPTH+1)-1:0] o_credits,
  output logic                       o_error
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  TYPE           mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] credits_nxt;
  logic          issue;
  logic          pop;
  logic          push;
  logic          err_nxt;
  TYPE           head_nxt;

  // Handshake decode, pointer/occupancy/credit next-state and next head entry.
  always_comb begin
    issue       = i_issue_valid & o_issue_ready;
    pop         = o_valid & i_ready;
    // A full buffer still takes a result when the head leaves in the same cycle.
    push        = i_pipe_valid & ((count != FULL) | pop);
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    count_nxt   = count;
    credits_nxt = o_credits;

    if (push) begin
      wr_ptr_nxt = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    end
    if (pop) begin
      rd_ptr_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase

    // Issue is gated by o_issue_ready, so the decrement cannot underflow;
    // a pop with every credit already home is clamped and flagged.
    case ({issue, pop})
      2'b10:   credits_nxt = o_credits - 1'b1;
      2'b01:   credits_nxt = (o_credits == FULL) ? o_credits : o_credits + 1'b1;
      default: credits_nxt = o_credits;
    endcase

    err_nxt = o_error | (i_pipe_valid & ~push) | (pop & (o_credits == FULL));

    // The slot being written becomes the head only when it is the sole entry.
    head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? i_pipe_d : mem[rd_ptr_nxt];
  end

  // Buffer storage; contents are qualified by the occupancy counter.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_pipe_d;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_credits     <= FULL;
      o_issue_ready <= 1'b1;
      o_valid       <= 1'b0;
      o_d           <= '0;
      o_error       <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      count         <= count_nxt;
      o_credits     <= credits_nxt;
      o_issue_ready <= (credits_nxt != '0);
      o_valid       <= (count_nxt != '0);
      if (count_nxt != '0) begin
        o_d <= head_nxt;
      end
      o_error       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_std_delay_catcher.sv
// Bench for std_delay_catcher: a DEPTH=4 and a DEPTH=3 instance each sit behind
// a two-stage delay pipeline. A queue-style reference model predicts every
// output each cycle; table vectors and short sequences add explicit checks.
module tb_std_delay_catcher;

  localparam int MBUF    = 1024;
  localparam int SEQ_LIM = 20;

  logic       clk;
  logic       rst_n;
  logic       rdy;
  logic       iv4, iv3, pv4, pv3;
  logic [7:0] pd4, pd3;
  logic       ir4, ir3, ov4, ov3, er4, er3;
  logic [7:0] od4, od3;
  logic [2:0] cr4;
  logic [1:0] cr3;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance (0: DEPTH 4, 1: DEPTH 3).
  int         m_dep  [2];
  int         m_cred [2];
  logic       m_err  [2];
  int         m_wr   [2];
  int         m_rd   [2];
  logic [7:0] m_buf  [2][MBUF];
  logic       pipe_v [2][2];
  logic [7:0] pipe_d [2][2];
  int         seq    [2];

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       r;
    logic       ev;
    logic [7:0] ed;
    int         ec;
    logic       er;
  } vec_t;

  vec_t tbl [13];

  std_delay_catcher #(.DEPTH(4), .WIDTH(8)) dut4 (
    .i_clk(clk), .i_rst(rst_n),
    .i_issue_valid(iv4), .o_issue_ready(ir4),
    .i_pipe_valid(pv4), .i_pipe_d(pd4),
    .o_valid(ov4), .i_ready(rdy), .o_d(od4),
    .o_credits(cr4), .o_error(er4)
  );

  std_delay_catcher #(.DEPTH(3), .WIDTH(8)) dut3 (
    .i_clk(clk), .i_rst(rst_n),
    .i_issue_valid(iv3), .o_issue_ready(ir3),
    .i_pipe_valid(pv3), .i_pipe_d(pd3),
    .o_valid(ov3), .i_ready(rdy), .o_d(od3),
    .o_credits(cr3), .o_error(er3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cred[k] = m_dep[k];
      m_err[k]  = 1'b0;
      m_wr[k]   = 0;
      m_rd[k]   = 0;
      pipe_v[k][0] = 1'b0;
      pipe_v[k][1] = 1'b0;
      pipe_d[k][0] = 8'h00;
      pipe_d[k][1] = 8'h00;
    end
  endtask

  task automatic model_check(input int k);
    int    v, d, c, r, e;
    string n;
    if (k == 0) begin
      v = int'(ov4); d = int'(od4); c = int'(cr4); r = int'(ir4); e = int'(er4);
      n = "d4";
    end else begin
      v = int'(ov3); d = int'(od3); c = int'(cr3); r = int'(ir3); e = int'(er3);
      n = "d3";
    end
    chk({n, " valid"}, v, (m_wr[k] != m_rd[k]) ? 1 : 0);
    if (m_wr[k] != m_rd[k]) chk({n, " data"}, d, int'(m_buf[k][m_rd[k] % MBUF]));
    chk({n, " credits"}, c, m_cred[k]);
    chk({n, " issue_ready"}, r, (m_cred[k] != 0) ? 1 : 0);
    chk({n, " error"}, e, int'(m_err[k]));
  endtask

  // One clock cycle: check both DUTs against the model, drive, step the model.
  task automatic cycle(input logic iv, input logic [7:0] data, input logic r,
                       input logic inj, input logic [7:0] injd,
                       input logic nopipe, input logic seqmode);
    logic       ivk   [2];
    logic       pushk [2];
    logic [7:0] pdk   [2];
    logic       isu, pop;
    logic [7:0] pay;
    model_check(0);
    model_check(1);
    for (int k = 0; k < 2; k++) begin
      ivk[k]   = iv && (!seqmode || seq[k] < SEQ_LIM);
      pushk[k] = inj || pipe_v[k][1];
      pdk[k]   = inj ? injd : pipe_d[k][1];
    end
    iv4 = ivk[0]; iv3 = ivk[1]; rdy = r;
    pv4 = pushk[0]; pd4 = pdk[0];
    pv3 = pushk[1]; pd3 = pdk[1];
    for (int k = 0; k < 2; k++) begin
      isu = ivk[k] && (m_cred[k] != 0);
      pop = (m_wr[k] != m_rd[k]) && r;
      if (pop && m_cred[k] == m_dep[k]) m_err[k] = 1'b1;
      if (pop) m_rd[k]++;
      if (pushk[k]) begin
        if (m_wr[k] - m_rd[k] < m_dep[k]) begin
          m_buf[k][m_wr[k] % MBUF] = pdk[k];
          m_wr[k]++;
        end else begin
          m_err[k] = 1'b1;
        end
      end
      if (isu && !pop) m_cred[k]--;
      else if (!isu && pop && m_cred[k] < m_dep[k]) m_cred[k]++;
      pay = seqmode ? 8'(seq[k]) : data;
      if (isu && seqmode) seq[k]++;
      pipe_v[k][1] = pipe_v[k][0];
      pipe_d[k][1] = pipe_d[k][0];
      pipe_v[k][0] = isu && !nopipe;
      pipe_d[k][0] = pay;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    iv4 = 1'b0; iv3 = 1'b0; rdy = 1'b0; pv4 = 1'b0; pv3 = 1'b0;
    #1;
    chk({tag, " valid"}, int'(ov4), 0);
    chk({tag, " issue_ready"}, int'(ir4), 1);
    chk({tag, " credits"}, int'(cr4), 4);
    chk({tag, " error"}, int'(er4), 0);
    chk({tag, " d3 credits"}, int'(cr3), 3);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int drops4, drops3, seen4, seen3, got, exp_d;

  initial begin
    m_dep[0] = 4;
    m_dep[1] = 3;
    seq[0] = 0;
    seq[1] = 0;
    rst_n = 1'b0;
    iv4 = 1'b0; iv3 = 1'b0; rdy = 1'b0;
    pv4 = 1'b0; pv3 = 1'b0; pd4 = 8'h00; pd3 = 8'h00;
    model_reset();

    // Stall then drain: {iv, data, ready, exp valid, exp data, exp credits, exp issue_ready}
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 4, 1'b1};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 3, 1'b1};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 2, 1'b1};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h11, 1, 1'b1};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h11, 0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 2, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 3, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset values, then a reset landing with two entries buffered.
    chk("rst valid", int'(ov4), 0);
    chk("rst issue_ready", int'(ir4), 1);
    chk("rst credits", int'(cr4), 4);
    chk("rst error", int'(er4), 0);
    cycle(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("prerst valid", int'(ov4), 1);
    chk("prerst credits", int'(cr4), 2);
    async_reset("midrst");

    // Stall and drain vectors.
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d valid", i), int'(ov4), int'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d data", i), int'(od4), int'(tbl[i].ed));
      chk($sformatf("tbl%0d credits", i), int'(cr4), tbl[i].ec);
      chk($sformatf("tbl%0d issue_ready", i), int'(ir4), int'(tbl[i].er));
      cycle(tbl[i].iv, tbl[i].d, tbl[i].r, 1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Back-to-back stream of 20 sequence numbers with ready held high.
    drops4 = 0; drops3 = 0; seen4 = 0; seen3 = 0;
    for (int c = 0; c < 60; c++) begin
      if (c >= 3 && c < 23) begin
        chk($sformatf("stream4 valid c%0d", c), int'(ov4), 1);
        chk($sformatf("stream4 data c%0d", c), int'(od4), c - 3);
      end
      if (!ir4) drops4++;
      if (!ir3) drops3++;
      if (ov4) seen4++;
      if (ov3) seen3++;
      cycle(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("stream4 ready drops", drops4, 0);
    chk("stream3 ready dropped", (drops3 > 0) ? 1 : 0, 1);
    chk("stream4 items out", seen4, 20);
    chk("stream3 items out", seen3, 20);

    // Occupancy held at two with a push and a pop every cycle.
    cycle(1'b1, 8'h60, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h61, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      exp_d = (i < 2) ? 8'h60 + i : 8'h70 + i - 2;
      chk($sformatf("wrap valid %0d", i), int'(ov4), 1);
      chk($sformatf("wrap data %0d", i), int'(od4), exp_d);
      chk($sformatf("wrap credits %0d", i), int'(cr4), 2);
      cycle(1'b1, 8'h00, 1'b1, 1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
    end
    repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap drained credits", int'(cr4), 4);

    // Randomized traffic; credits make overflow impossible here.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
            1'b0, 8'h00, 1'b0, 1'b0);
    end
    repeat (10) cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("random drained valid", int'(ov4), 0);
    chk("random no error", int'(er4), 0);

    // Overflow: full buffer, consumer stalled, a stray result arrives.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'(8'h81 + i), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("full credits", int'(cr4), 0);
    chk("full error before", int'(er4), 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("ovf error", int'(er4), 1);
    got = 0;
    for (int i = 0; i < 8; i++) begin
      if (ov4) begin
        chk($sformatf("ovf drain %0d", got), int'(od4), 8'h81 + got);
        got++;
      end
      chk($sformatf("ovf sticky %0d", i), int'(er4), 1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("ovf drained count", got, 4);

    // Pop while every credit is home is an inconsistency and is flagged.
    async_reset("rst2");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
    chk("orphan valid", int'(ov4), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("orphan error", int'(er4), 1);
    chk("orphan credits", int'(cr4), 4);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    async_reset("rst3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
